// File: rtl/wbuf_rd_sched_if.sv
// Request/response bundle between the weight-buffer read scheduler and its
// surroundings.
//   cmd_*      : tile-walk command handshake (valid/ready) and its fields
//   hold       : per-cycle issue suppression
//   *_sel      : per-lane read request to the 6-bank dual-port buffer
//   rd_*       : read-side markers aligned with the buffer's 1-cycle dout
//   busy, done : command status
// master = command source / result consumer, slave = scheduler.
interface wbuf_rd_sched_if #(
  parameter int TW     = 12,
  parameter int ADDR_W = 10
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [TW-1:0]          cmd_base;
  logic [TW-1:0]          cmd_stride;
  logic [TW-1:0]          cmd_gstep;
  logic [TW-1:0]          cmd_len;
  logic                   hold;
  logic [3:0][2:0]        bank_sel;
  logic [3:0][ADDR_W-1:0] addr_sel;
  logic [3:0]             en_sel;
  logic [3:0]             port_sel;
  logic [3:0]             rd_lane_vld;
  logic                   rd_group_last;
  logic                   busy;
  logic                   done;

  modport master (
    output cmd_valid, cmd_base, cmd_stride, cmd_gstep, cmd_len, hold,
    input  cmd_ready, bank_sel, addr_sel, en_sel, port_sel,
           rd_lane_vld, rd_group_last, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_stride, cmd_gstep, cmd_len, hold,
    output cmd_ready, bank_sel, addr_sel, en_sel, port_sel,
           rd_lane_vld, rd_group_last, busy, done
  );
endinterface

// File: rtl/wbuf_rd_sched.sv
// Read scheduler for the 4-lane request port of the 6-bank dual-port weight
// buffer. A command walks cmd_len groups of 4 tiles (lane k = base + k*stride,
// group base advancing by gstep). Each beat grants pending lanes in order,
// at most two per bank (first on port A, second on port B); lanes that lose
// stay pending for the next beat.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wbuf_rd_sched_if.slave (command, hold, buffer request,
//                read-side lane valid / group last, busy, done)
module wbuf_rd_sched #(
  parameter int N_BANK = 6,
  parameter int DEPTH  = 683,
  parameter int N_TILE = 4096,
  parameter int TW     = $clog2(N_TILE),
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  wbuf_rd_sched_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE,
    ZERO,
    ISSUE
  } state_t;

  state_t            state, state_d;
  logic [TW-1:0]     base_q, base_d;
  logic [TW-1:0]     stride_q, stride_d;
  logic [TW-1:0]     gstep_q, gstep_d;
  logic [TW-1:0]     rem_q, rem_d;
  logic [3:0]        pend_q, pend_d;

  logic [3:0]        grant;
  logic [3:0]        port;
  logic              grp_done;
  logic              cmd_last;

  logic [TW-1:0]     tile [4];
  logic [2:0]        bank [4];
  logic [ADDR_W-1:0] addr [4];
  logic [1:0]        used [N_BANK];

  logic [3:0]        rd_lane_vld_q;
  logic              rd_group_last_q;
  logic              done_q;

  // Tile index wraps naturally in TW bits (N_TILE is a power of two).
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      tile[k] = base_q + TW'(k) * stride_q;
      bank[k] = 3'(tile[k] % TW'(N_BANK));
      addr[k] = ADDR_W'(tile[k] / TW'(N_BANK));
    end
  end

  always_comb begin
    state_d  = state;
    base_d   = base_q;
    stride_d = stride_q;
    gstep_d  = gstep_q;
    rem_d    = rem_q;
    pend_d   = pend_q;
    grant    = '0;
    port     = '0;
    grp_done = 1'b0;
    cmd_last = 1'b0;
    for (int unsigned b = 0; b < N_BANK; b++) used[b] = '0;

    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          base_d   = bus.cmd_base;
          stride_d = bus.cmd_stride;
          gstep_d  = bus.cmd_gstep;
          rem_d    = bus.cmd_len;
          if (bus.cmd_len != '0) begin
            pend_d  = '1;
            state_d = ISSUE;
          end else begin
            state_d = ZERO;
          end
        end
      end
      ZERO: begin
        cmd_last = 1'b1;
        state_d  = IDLE;
      end
      ISSUE: begin
        if (!bus.hold) begin
          // In-order walk; lane 0 of the remaining set always wins, so every
          // beat issues at least one lane.
          for (int unsigned k = 0; k < 4; k++) begin
            if (pend_q[k] && used[bank[k]] != 2'd2) begin
              grant[k]       = 1'b1;
              port[k]        = (used[bank[k]] != 2'd0);
              used[bank[k]]  = used[bank[k]] + 2'd1;
            end
          end
          pend_d = pend_q & ~grant;
          if (pend_d == '0) begin
            grp_done = 1'b1;
            if (rem_q == TW'(1)) begin
              cmd_last = 1'b1;
              state_d  = IDLE;
            end else begin
              base_d = base_q + gstep_q;
              rem_d  = rem_q - TW'(1);
              pend_d = '1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      base_q          <= '0;
      stride_q        <= '0;
      gstep_q         <= '0;
      rem_q           <= '0;
      pend_q          <= '0;
      rd_lane_vld_q   <= '0;
      rd_group_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state           <= state_d;
      base_q          <= base_d;
      stride_q        <= stride_d;
      gstep_q         <= gstep_d;
      rem_q           <= rem_d;
      pend_q          <= pend_d;
      rd_lane_vld_q   <= grant;
      rd_group_last_q <= grp_done;
      done_q          <= cmd_last;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      bus.bank_sel[k] = grant[k] ? bank[k] : '0;
      bus.addr_sel[k] = grant[k] ? addr[k] : '0;
    end
  end

  assign bus.en_sel        = grant;
  assign bus.port_sel      = port;
  assign bus.cmd_ready     = (state == IDLE);
  assign bus.busy          = (state != IDLE);
  assign bus.rd_lane_vld   = rd_lane_vld_q;
  assign bus.rd_group_last = rd_group_last_q;
  assign bus.done          = done_q;

endmodule
